// File: rtl/elem_sram_arbiter.sv
// elem_sram_arbiter: shares the ELEM0 SRAM port between GEMM requant write-back
// (requester 0, fixed priority), element-wise read-out and AXI-stream output read
// (requesters 1..NUM_REQ-1, round-robin with a starvation override).
// Commands are registered toward the SRAM; read data is routed back to its
// requester through a tag pipeline that tracks the SRAM read latency.
module elem_sram_arbiter #(
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           sram_en,
    output logic                           sram_we,
    output logic [ADDR_WIDTH-1:0]          sram_addr,
    output logic [DATA_WIDTH-1:0]          sram_wdata,
    input  logic [DATA_WIDTH-1:0]          sram_rdata,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [IDW-1:0] FIRST_LOW = IDW'(1);
    localparam logic [IDW-1:0] LAST_LOW  = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]        r_rr_ptr;
    logic [SCW-1:0]        r_starve_cnt;
    logic                  w_low_any;
    logic                  w_starved;
    logic                  w_rr_hit_hi;
    logic [IDW-1:0]        w_rr_hi;
    logic [IDW-1:0]        w_rr_lo;
    logic [IDW-1:0]        w_rr_idx;
    logic                  w_grant_vld;
    logic [IDW-1:0]        w_grant_id;
    logic                  w_low_grant;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [NUM_REQ-1:0]    w_rsp_hot;

    // Tag stage 0 is aligned with sram_en; stage READ_LATENCY with sram_rdata.
    logic [READ_LATENCY:0] r_tag_vld;
    logic [IDW-1:0]        r_tag_id [READ_LATENCY+1];

    assign w_low_any = |req_valid[NUM_REQ-1:1];
    assign w_starved = (r_starve_cnt == SCW'(STARVE_LIMIT));

    // Round-robin pick: first valid low-priority requester at or after r_rr_ptr,
    // falling back to the lowest valid one (wrap within 1..NUM_REQ-1).
    always_comb begin
        w_rr_hit_hi = 1'b0;
        w_rr_hi     = FIRST_LOW;
        w_rr_lo     = FIRST_LOW;
        for (int i = NUM_REQ - 1; i >= 1; i--) begin
            if (req_valid[i]) begin
                w_rr_lo = IDW'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_rr_hit_hi = 1'b1;
                    w_rr_hi     = IDW'(i);
                end
            end
        end
        w_rr_idx = w_rr_hit_hi ? w_rr_hi : w_rr_lo;
    end

    // Grant decision: starvation override, then requester 0, then round-robin.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        if (enable && !rst) begin
            if (w_starved && w_low_any) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_rr_idx;
            end else if (req_valid[0]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = '0;
            end else if (w_low_any) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_rr_idx;
            end
        end
    end

    assign w_low_grant = w_grant_vld && (w_grant_id != '0);

    // One-hot ready plus command mux for the granted requester.
    always_comb begin
        w_ready = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_vld && (w_grant_id == IDW'(i))) begin
                w_ready[i] = 1'b1;
                w_we       = req_we[i];
                w_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready = w_ready;

    // Round-robin pointer and starvation counter; both frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= FIRST_LOW;
            r_starve_cnt <= '0;
        end else if (enable) begin
            if (w_low_grant) begin
                r_rr_ptr     <= (w_grant_id == LAST_LOW) ? FIRST_LOW : w_grant_id + IDW'(1);
                r_starve_cnt <= '0;
            end else if (!w_low_any) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + SCW'(1);
            end
        end
    end

    // Registered SRAM command; address and write data hold between commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            grant_id   <= '0;
        end else begin
            sram_en <= w_grant_vld;
            sram_we <= w_grant_vld & w_we;
            if (w_grant_vld) begin
                sram_addr  <= w_addr;
                sram_wdata <= w_wdata;
                grant_id   <= w_grant_id;
            end
        end
    end

    // Read tag pipeline; a reset discards every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int s = 0; s <= READ_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_grant_vld & ~w_we;
            r_tag_id[0]  <= w_grant_id;
            for (int s = 1; s <= READ_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    // Decode the emerging tag into a one-hot response strobe.
    always_comb begin
        w_rsp_hot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_tag_vld[READ_LATENCY] && (r_tag_id[READ_LATENCY] == IDW'(i))) begin
                w_rsp_hot[i] = 1'b1;
            end
        end
    end

    // Registered response; rsp_data only updates when a read returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= w_rsp_hot;
            if (r_tag_vld[READ_LATENCY]) begin
                rsp_data <= sram_rdata;
            end
        end
    end

    assign busy = (|w_ready) | sram_en | (|r_tag_vld) | (|rsp_valid);

endmodule

// File: tb/tb_elem_sram_arbiter.sv
// Directed bench for elem_sram_arbiter with a one-cycle-latency SRAM model.
module tb_elem_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [17:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    logic [53:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        sram_en;
    logic        sram_we;
    logic [17:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic [1:0]  grant_id;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    logic [7:0] mem [0:255];

    assign req_addr  = {a2, a1, a0};
    assign req_wdata = {d2, d1, d0};

    always #5 clk = ~clk;

    elem_sram_arbiter dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .grant_id(grant_id), .busy(busy)
    );

    // SRAM model: preloaded on reset, read data valid one cycle after sram_en.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            mem[5] <= 8'h5A;
            mem[6] <= 8'h66;
            sram_rdata <= 8'h00;
        end else if (sram_en) begin
            if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
            else sram_rdata <= mem[sram_addr[7:0]];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 3'b000;
        req_we    = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        req_valid = 3'b111; req_we = 3'b000;
        a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
        #2;
        vecs++; if (req_ready !== 3'b000) begin errs++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        vecs++; if ({sram_en, sram_we, sram_addr, sram_wdata, grant_id, rsp_valid, rsp_data, busy} !== '0) begin
            errs++; $display("FAIL reset_outs got en=%b we=%b addr=%h wd=%h gid=%0d rv=%b rd=%h busy=%b exp all 0",
                sram_en, sram_we, sram_addr, sram_wdata, grant_id, rsp_valid, rsp_data, busy);
        end
        idle_inputs();
        cyc(); cyc();
        rst = 1'b0;
        // grant a read to requester 1 (moves rr_ptr to 2), then reset with it in flight
        cyc();
        req_valid = 3'b010; a1 = 18'd5;
        #1;
        vecs++; if (req_ready !== 3'b010) begin errs++; $display("FAIL pre_rst_grant got=%b exp=010", req_ready); end
        cyc();
        idle_inputs();
        vecs++; if (sram_en !== 1'b1) begin errs++; $display("FAIL pre_rst_issue got=%b exp=1", sram_en); end
        rst = 1'b1;
        #1;
        vecs++; if ({sram_en, sram_we, sram_addr, sram_wdata, grant_id, rsp_valid, rsp_data, busy, req_ready} !== '0) begin
            errs++; $display("FAIL async_rst_outs got en=%b addr=%h gid=%0d rv=%b busy=%b exp all 0",
                sram_en, sram_addr, grant_id, rsp_valid, busy);
        end
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            vecs++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL rst_discard c=%0d got=%b exp=000", c, rsp_valid); end
        end
        req_valid = 3'b110; a2 = 18'd6;
        #1;
        vecs++; if (req_ready !== 3'b010) begin errs++; $display("FAIL rst_rr_ptr got=%b exp=010", req_ready); end
        idle_inputs();
    endtask

    task automatic test_single_read();
        cyc();
        req_valid = 3'b010; req_we = 3'b000; a1 = 18'h00005;
        #1;
        vecs++; if (req_ready !== 3'b010) begin errs++; $display("FAIL sr_ready got=%b exp=010", req_ready); end
        cyc();
        idle_inputs();
        #1;
        vecs++; if ({sram_en, sram_we, sram_addr, grant_id} !== {1'b1, 1'b0, 18'h00005, 2'd1}) begin
            errs++; $display("FAIL sr_cmd got en=%b we=%b addr=%h gid=%0d exp en=1 we=0 addr=00005 gid=1",
                sram_en, sram_we, sram_addr, grant_id);
        end
        vecs++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL sr_early_c1 got=%b exp=000", rsp_valid); end
        cyc();
        vecs++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL sr_early_c2 got=%b exp=000", rsp_valid); end
        cyc();
        vecs++; if ({rsp_valid, rsp_data} !== {3'b010, 8'h5A}) begin
            errs++; $display("FAIL sr_rsp got rv=%b rd=%h exp rv=010 rd=5a", rsp_valid, rsp_data);
        end
        cyc();
        vecs++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL sr_rsp_pulse got=%b exp=000", rsp_valid); end
    endtask

    task automatic test_priority();
        int wcnt = 0;
        logic [1:0]  prev_id = 2'd0;
        logic [17:0] prev_addr = '0;
        logic [7:0]  prev_data = '0;
        logic [2:0]  exp;
        for (int c = 0; c < 18; c++) begin
            cyc();
            req_valid = 3'b101; req_we = 3'b001;
            a0 = 18'(10 + wcnt % 4); d0 = 8'(8'h80 + wcnt); a2 = 18'd6;
            #1;
            exp = (c == 8 || c == 17) ? 3'b100 : 3'b001;
            vecs++; if (req_ready !== exp) begin errs++; $display("FAIL prio_ready c=%0d got=%b exp=%b", c, req_ready, exp); end
            if (c > 0) begin
                vecs++; if ({sram_en, grant_id} !== {1'b1, prev_id}) begin
                    errs++; $display("FAIL prio_issue c=%0d got en=%b gid=%0d exp en=1 gid=%0d", c, sram_en, grant_id, prev_id);
                end
                if (prev_id == 2'd0) begin
                    vecs++; if ({sram_we, sram_addr, sram_wdata} !== {1'b1, prev_addr, prev_data}) begin
                        errs++; $display("FAIL prio_wr c=%0d got we=%b addr=%h wd=%h exp we=1 addr=%h wd=%h",
                            c, sram_we, sram_addr, sram_wdata, prev_addr, prev_data);
                    end
                end
            end
            if (exp == 3'b100) begin
                prev_id = 2'd2;
            end else begin
                prev_id = 2'd0; prev_addr = a0; prev_data = d0; wcnt++;
            end
        end
        cyc();
        idle_inputs();
        for (int c = 0; c < 4; c++) cyc();
    endtask

    task automatic test_round_robin();
        logic [1:0] eid;
        for (int c = 0; c < 9; c++) begin
            cyc();
            if (c < 6) begin
                req_valid = 3'b110; req_we = 3'b000; a1 = 18'd5; a2 = 18'd6;
            end else begin
                idle_inputs();
            end
            #1;
            if (c < 6) begin
                eid = (c % 2 == 0) ? 2'd1 : 2'd2;
                vecs++; if (req_ready !== (3'b001 << eid)) begin
                    errs++; $display("FAIL rr_ready c=%0d got=%b exp id %0d", c, req_ready, eid);
                end
            end
            if (c >= 1 && c <= 6) begin
                eid = ((c - 1) % 2 == 0) ? 2'd1 : 2'd2;
                vecs++; if ({sram_en, grant_id, sram_addr} !== {1'b1, eid, (eid == 2'd1) ? 18'd5 : 18'd6}) begin
                    errs++; $display("FAIL rr_issue c=%0d got en=%b gid=%0d addr=%h exp gid=%0d", c, sram_en, grant_id, sram_addr, eid);
                end
            end
            if (c >= 3) begin
                eid = ((c - 3) % 2 == 0) ? 2'd1 : 2'd2;
                vecs++; if ({rsp_valid, rsp_data} !== {3'b001 << eid, (eid == 2'd1) ? 8'h5A : 8'h66}) begin
                    errs++; $display("FAIL rr_rsp c=%0d got rv=%b rd=%h exp id %0d", c, rsp_valid, rsp_data, eid);
                end
            end
        end
        cyc();
    endtask

    task automatic test_raw();
        cyc();
        req_valid = 3'b001; req_we = 3'b001; a0 = 18'd7; d0 = 8'h33;
        #1;
        vecs++; if (req_ready !== 3'b001) begin errs++; $display("FAIL raw_wr_ready got=%b exp=001", req_ready); end
        cyc();
        req_valid = 3'b010; req_we = 3'b000; a1 = 18'd7;
        #1;
        vecs++; if (req_ready !== 3'b010) begin errs++; $display("FAIL raw_rd_ready got=%b exp=010", req_ready); end
        cyc();
        idle_inputs();
        cyc();
        cyc();
        vecs++; if ({rsp_valid, rsp_data} !== {3'b010, 8'h33}) begin
            errs++; $display("FAIL raw_rsp got rv=%b rd=%h exp rv=010 rd=33", rsp_valid, rsp_data);
        end
        cyc();
    endtask

    task automatic test_enable_gating();
        cyc();
        req_valid = 3'b010; req_we = 3'b000; a1 = 18'd5;
        #1;
        vecs++; if (req_ready !== 3'b010) begin errs++; $display("FAIL en_rd1_ready got=%b exp=010", req_ready); end
        cyc();
        req_valid = 3'b100; a2 = 18'd6;
        #1;
        vecs++; if (req_ready !== 3'b100) begin errs++; $display("FAIL en_rd2_ready got=%b exp=100", req_ready); end
        for (int c = 2; c < 7; c++) begin
            cyc();
            enable = 1'b0; req_valid = 3'b100;
            #1;
            vecs++; if (req_ready !== 3'b000) begin errs++; $display("FAIL en_gate_ready c=%0d got=%b exp=000", c, req_ready); end
            vecs++; if (busy !== (c <= 4)) begin errs++; $display("FAIL en_busy c=%0d got=%b exp=%b", c, busy, (c <= 4)); end
            if (c == 3) begin
                vecs++; if ({rsp_valid, rsp_data} !== {3'b010, 8'h5A}) begin
                    errs++; $display("FAIL en_rsp1 got rv=%b rd=%h exp rv=010 rd=5a", rsp_valid, rsp_data);
                end
            end else if (c == 4) begin
                vecs++; if ({rsp_valid, rsp_data} !== {3'b100, 8'h66}) begin
                    errs++; $display("FAIL en_rsp2 got rv=%b rd=%h exp rv=100 rd=66", rsp_valid, rsp_data);
                end
            end else begin
                vecs++; if (rsp_valid !== 3'b000) begin errs++; $display("FAIL en_rsp_idle c=%0d got=%b exp=000", c, rsp_valid); end
            end
        end
        cyc();
        enable = 1'b1;
        #1;
        vecs++; if (req_ready !== 3'b100) begin errs++; $display("FAIL en_resume got=%b exp=100", req_ready); end
        cyc();
        idle_inputs();
        for (int c = 0; c < 4; c++) cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_raw();
        test_enable_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/elem_sram_arbiter.md
Name: elem_sram_arbiter

Overview:
- Shares the single ELEM0 SRAM port among up to NUM_REQ requesters:
  - requester 0: GEMM requant write-back.
  - requester 1: element-wise read-out.
  - requester 2: AXI-stream output read.
- Fixed priority goes to requester 0. The remaining requesters are served round-robin, with a starvation override.
- SRAM commands are registered. Read data is returned to the originating requester through a tag pipeline.
- Sits between the GEMM/element_wise/axi_stream_output blocks and sram_controller's elem port.

Parameters:
- ADDR_WIDTH, 18, SRAM address width (MAX_ADDR_WIDTH).
- DATA_WIDTH, 8, SRAM data width.
- NUM_REQ, 3, number of requesters (>=2).
- READ_LATENCY, 1, SRAM cycles from registered sram_en to valid sram_rdata.
- STARVE_LIMIT, 8, consecutive denied cycles before low-priority override.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  when low, no new grants; in-flight reads still complete
- req_valid  in  NUM_REQ  per-requester request
- req_we  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  grant/accept, at most one bit high
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- sram_en  out  1  SRAM port enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data
- grant_id  out  $clog2(NUM_REQ)  registered id of last accepted requester
- busy  out  1  any read in flight or any command issued this cycle

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; rr_ptr=1; starve_cnt=0; tag pipeline cleared.
- Handshake:
  - Transfer when req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid, enable and arbiter state.
  - Requesters hold valid/we/addr/wdata stable until accepted; the arbiter never relies on a valid being withdrawn.
  - req_ready is 0 whenever enable=0.
- Arbitration, evaluated each cycle with enable=1:
  - Let L = any req_valid[1..NUM_REQ-1].
  - If starve_cnt==STARVE_LIMIT and L: grant the first valid requester at or after rr_ptr (wrapping within 1..NUM_REQ-1), even if requester 0 is valid.
  - Else if req_valid[0]: grant requester 0.
  - Else if L: round-robin from rr_ptr.
  - After a low-priority grant to k: rr_ptr = k+1, wrapping to 1 after NUM_REQ-1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when L && no low-priority grant.
  - Clears to 0 on any low-priority grant or when !L.
  - Holds when enable=0.
- Command stage:
  - On accept, on the next clk edge: sram_en=1, sram_we=req_we[i], sram_addr, sram_wdata, grant_id=i.
  - Otherwise sram_en=0 and sram_we=0; addr/wdata hold their values.
  - One command per cycle, full throughput, no bubbles.
- Read return:
  - Each read pushes tag {valid, id} into a READ_LATENCY-deep shift register aligned with sram_en.
  - When the tag emerges: rsp_valid[id]=1 for one cycle and rsp_data=sram_rdata, both registered.
  - Total latency accept->rsp_valid = 2+READ_LATENCY cycles (3 at default).
  - Writes produce no response.
  - Responses return in issue order; there is no back-pressure on rsp.
- Read-after-write: commands reach the SRAM in accept order. A read accepted the cycle after a write to the same address returns the new data.
- Boundaries:
  - NUM_REQ=2: round-robin degenerates to requester 1 only.
  - enable falling mid-stream: the accepted command still issues and pending reads still return; busy falls after the last rsp_valid.
  - rst mid-operation: in-flight reads are discarded immediately, no rsp_valid is produced, and rr_ptr and starve_cnt are reset.

Test Plan:
- Reset:
  - Stimulus: assert rst asynchronously with reads in flight.
  - Required: all outputs 0 immediately; no rsp_valid after release; rr_ptr=1 (next contended grant goes to 1).
- Single read:
  - Stimulus: req 1 reads addr 0x00005; SRAM preloaded 0x5A.
  - Required: req_ready[1] in cycle 0; sram_en/addr=5 in cycle 1; rsp_valid[1]=1 with rsp_data=0x5A in cycle 3.
- Priority:
  - Stimulus: req 0 writes addr 10..13 continuously while req 2 reads.
  - Required: req 0 granted for the first 8 cycles; req 2 granted on cycle 8 (starve override); starve_cnt returns to 0; req 0 resumes on the next cycle.
- Round-robin:
  - Stimulus: req 1 and req 2 both continuously valid, req 0 idle.
  - Required: grants alternate 1,2,1,2; grant_id sequence matches; no cycle without a grant.
- RAW ordering:
  - Stimulus: req 0 writes 0x33 to addr 7; next cycle req 1 reads addr 7.
  - Required: rsp_data=0x33 to requester 1.
- Enable gating:
  - Stimulus: drop enable with two reads in flight and req 2 valid.
  - Required: req_ready stays 0; both rsp_valid still appear; busy deasserts the cycle after the last response.
